// File: rtl/add_if_unit.sv
// add_if_unit: adder endpoint with a live combinational sum and a
// registered, valid/ready-handshaked sum path through a small FIFO.
//
// Ports:
//   clk, rst_n      rising-edge clock, async active-low reset
//   a, b            unsigned operands (WIDTH bits each)
//   in_valid/ready  producer handshake; accept on in_valid && in_ready
//   y_comb          a + b, WIDTH+1 bits, purely combinational
//   y               sum at FIFO head (holds last popped value when empty)
//   out_valid/ready consumer handshake; pop on out_valid && out_ready
//   count           number of buffered results
module add_if_unit #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [WIDTH-1:0]           a,
   input  logic [WIDTH-1:0]           b,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [WIDTH:0]             y_comb,
   output logic [WIDTH:0]             y,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [WIDTH:0] mem [DEPTH];
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_ptr;
   logic [CW-1:0]  cnt;
   logic [WIDTH:0] y_last;
   logic           ready_q;
   logic           push;
   logic           pop;

   assign y_comb = {1'b0, a} + {1'b0, b};

   assign out_valid = (cnt != '0);
   assign pop       = out_valid && out_ready;
   // ready_q keeps in_ready low until the first edge after reset release
   assign in_ready  = ready_q && ((cnt < FULL) || pop);
   assign push      = in_valid && in_ready;
   assign count     = cnt;

   // Empty buffer shows the most recently popped sum.
   assign y = out_valid ? mem[rd_ptr] : y_last;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q <= 1'b0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         cnt     <= '0;
         y_last  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         ready_q <= 1'b1;
         if (push) begin
            mem[wr_ptr] <= y_comb;
            wr_ptr      <= nxt(wr_ptr);
         end
         if (pop) begin
            y_last <= mem[rd_ptr];
            rd_ptr <= nxt(rd_ptr);
         end
         unique case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_add_if_unit.sv
// tb_add_if_unit: directed self-checking bench for add_if_unit.
// Inputs change at #1 after posedge; outputs sampled at #1 after posedge.
module tb_add_if_unit;

   logic       clk;
   logic       rst_n;
   logic [3:0] a;
   logic [3:0] b;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] y_comb;
   logic [4:0] y;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] count;

   int vecs;
   int errs;

   add_if_unit #(.WIDTH(4), .DEPTH(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .y_comb    (y_comb),
      .y         (y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      vecs++;
      if (out_valid !== 1'b0 || y !== 5'd0 || count !== 2'd0) begin
         errs++;
         $display("FAIL reset_state: valid=%b y=%0d count=%0d want 0/0/0",
                  out_valid, y, count);
      end
      vecs++;
      if (in_ready !== 1'b0) begin
         errs++;
         $display("FAIL reset_ready: in_ready=%b want 0", in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      vecs++;
      if (in_ready !== 1'b0) begin
         errs++;
         $display("FAIL release_ready_pre: in_ready=%b want 0", in_ready);
      end
      step();
      vecs++;
      if (in_ready !== 1'b1) begin
         errs++;
         $display("FAIL release_ready: in_ready=%b want 1", in_ready);
      end
   endtask

   task automatic test_comb();
      in_valid = 1'b0;
      a = 4'd3;
      b = 4'd4;
      #1;
      vecs++;
      if (y_comb !== 5'd7) begin
         errs++;
         $display("FAIL comb_3_4: y_comb=%0d want 7", y_comb);
      end
      #9;
      a = 4'd5;
      #1;
      vecs++;
      if (y_comb !== 5'd9) begin
         errs++;
         $display("FAIL comb_5_4: y_comb=%0d want 9", y_comb);
      end
      #9;
      b = 4'd7;
      #1;
      vecs++;
      if (y_comb !== 5'd12) begin
         errs++;
         $display("FAIL comb_5_7: y_comb=%0d want 12", y_comb);
      end
      vecs++;
      if (out_valid !== 1'b0 || count !== 2'd0) begin
         errs++;
         $display("FAIL comb_idle: valid=%b count=%0d want 0/0",
                  out_valid, count);
      end
      step();
   endtask

   task automatic test_carry();
      a = 4'd15;
      b = 4'd15;
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1;
      vecs++;
      if (y_comb !== 5'd30) begin
         errs++;
         $display("FAIL carry_comb: y_comb=%0d want 30", y_comb);
      end
      step();
      in_valid = 1'b0;
      vecs++;
      if (y !== 5'b11110 || out_valid !== 1'b1 || count !== 2'd1) begin
         errs++;
         $display("FAIL carry_out: y=%0d valid=%b count=%0d want 30/1/1",
                  y, out_valid, count);
      end
      step();
      vecs++;
      if (out_valid !== 1'b0 || count !== 2'd0 || y !== 5'd30) begin
         errs++;
         $display("FAIL carry_drain: valid=%b count=%0d y=%0d want 0/0/30",
                  out_valid, count, y);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid = 1'b1;
      a = 4'd1;
      b = 4'd2;
      step();
      a = 4'd3;
      b = 4'd4;
      step();
      a = 4'd5;
      b = 4'd6;
      #1;
      vecs++;
      if (in_ready !== 1'b0 || count !== 2'd2 || y !== 5'd3) begin
         errs++;
         $display("FAIL bp_full: rdy=%b count=%0d y=%0d want 0/2/3",
                  in_ready, count, y);
      end
      step();
      vecs++;
      if (count !== 2'd2 || y !== 5'd3 || out_valid !== 1'b1) begin
         errs++;
         $display("FAIL bp_hold: count=%0d y=%0d valid=%b want 2/3/1",
                  count, y, out_valid);
      end
      out_ready = 1'b1;
      #1;
      vecs++;
      if (in_ready !== 1'b1) begin
         errs++;
         $display("FAIL bp_ready_pop: in_ready=%b want 1", in_ready);
      end
      step();
      in_valid = 1'b0;
      vecs++;
      if (y !== 5'd7 || count !== 2'd2) begin
         errs++;
         $display("FAIL bp_pop1: y=%0d count=%0d want 7/2", y, count);
      end
      step();
      vecs++;
      if (y !== 5'd11 || count !== 2'd1) begin
         errs++;
         $display("FAIL bp_pop2: y=%0d count=%0d want 11/1", y, count);
      end
      step();
      vecs++;
      if (out_valid !== 1'b0 || count !== 2'd0) begin
         errs++;
         $display("FAIL bp_empty: valid=%b count=%0d want 0/0",
                  out_valid, count);
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a = 4'(i);
         b = 4'(i);
         in_valid = 1'b1;
         step();
         vecs++;
         if (y !== 5'(2 * i) || out_valid !== 1'b1 || count !== 2'd1) begin
            errs++;
            $display("FAIL b2b_%0d: y=%0d valid=%b count=%0d want %0d/1/1",
                     i, y, out_valid, count, 2 * i);
         end
      end
      in_valid = 1'b0;
      step();
      vecs++;
      if (count !== 2'd0 || out_valid !== 1'b0) begin
         errs++;
         $display("FAIL b2b_drain: count=%0d valid=%b want 0/0",
                  count, out_valid);
      end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      in_valid = 1'b1;
      a = 4'd1;
      b = 4'd1;
      step();
      a = 4'd2;
      b = 4'd3;
      step();
      in_valid = 1'b0;
      vecs++;
      if (count !== 2'd2) begin
         errs++;
         $display("FAIL arst_fill: count=%0d want 2", count);
      end
      #2;
      rst_n = 1'b0;
      #1;
      vecs++;
      if (out_valid !== 1'b0 || y !== 5'd0 || count !== 2'd0 ||
          in_ready !== 1'b0) begin
         errs++;
         $display("FAIL arst_clear: valid=%b y=%0d count=%0d rdy=%b want 0/0/0/0",
                  out_valid, y, count, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      a = 4'd2;
      b = 4'd2;
      in_valid = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      vecs++;
      if (y !== 5'd4 || out_valid !== 1'b1) begin
         errs++;
         $display("FAIL arst_after: y=%0d valid=%b want 4/1", y, out_valid);
      end
   endtask

   task automatic test_idle_hold();
      step();
      for (int i = 0; i < 10; i++) begin
         vecs++;
         if (y !== 5'd4 || out_valid !== 1'b0) begin
            errs++;
            $display("FAIL idle_%0d: y=%0d valid=%b want 4/0",
                     i, y, out_valid);
         end
         step();
      end
   endtask

   initial begin
      vecs = 0;
      errs = 0;
      rst_n = 1'b0;
      a = '0;
      b = '0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_comb();
      test_carry();
      test_backpressure();
      test_back_to_back();
      test_async_reset();
      test_idle_hold();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
